// File: rtl/tx_pkg.sv
// Shared types and constants for the transmitter carrier/keyer slice.
package tx_pkg;

    localparam int unsigned DEF_ACC_W = 32;
    localparam int unsigned DEF_LVL_W = 4;
    localparam int unsigned F_CLK_HZ  = 12_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } tx_state_e;

    // Rounded tuning word for a target frequency at the default accumulator width.
    function automatic logic [DEF_ACC_W-1:0] tw_from_hz(input longint unsigned f_hz);
        longint unsigned num;
        num = (f_hz << DEF_ACC_W) + 64'(F_CLK_HZ / 2);
        return DEF_ACC_W'(num / 64'(F_CLK_HZ));
    endfunction

endpackage

// File: rtl/tx_nco_keyer_key_debounce.sv
// Key input synchroniser followed by a consecutive-stable-cycle debouncer.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] db_cnt;

    // Two-flop synchroniser for the asynchronous key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new key level only after it has differed for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            key_db <= 1'b0;
        end else if (sync_q2 == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            db_cnt <= '0;
            key_db <= sync_q2;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_nco_keyer.sv
// NCO carrier generator with a ramped, PWM-gated keyer to soften key clicks.
module tx_nco_keyer
    import tx_pkg::*;
#(
    parameter int unsigned ACC_W        = DEF_ACC_W,
    parameter int unsigned LVL_W        = DEF_LVL_W,
    parameter int unsigned RAMP_DIV     = 64,
    parameter int unsigned DEBOUNCE_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in,
    input  logic [ACC_W-1:0] tw_data,
    input  logic             tw_valid,
    output logic             tw_ready,
    output logic             rf_out,
    output logic             tx_active,
    output logic [LVL_W:0]   level
);

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RAMP_DIV - 1);
    localparam logic [LVL_W:0]   LVL_MAX   = {1'b1, {LVL_W{1'b0}}};
    localparam logic [LVL_W:0]   LVL_ONE   = {{LVL_W{1'b0}}, 1'b1};
    localparam logic [LVL_W:0]   LVL_ZERO  = '0;

    logic             key_db;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] tw;
    logic [LVL_W-1:0] pcnt;
    logic             carrier;
    logic             gate;

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [LVL_W:0]   level_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             div_done;
    logic             tx_active_nxt;
    logic             tw_ready_nxt;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .key_db (key_db)
    );

    // Phase accumulator and tuning-word register; retuning never resets phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            tw  <= '0;
        end else begin
            acc <= acc + tw;
            if (tw_valid && tw_ready) begin
                tw <= tw_data;
            end
        end
    end

    // Free-running PWM phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + LVL_W'(1);
        end
    end

    assign carrier = acc[ACC_W-1];
    assign gate    = ({1'b0, pcnt} < level);

    // Gated carrier to the output pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_out <= 1'b0;
        end else begin
            rf_out <= carrier & gate;
        end
    end

    // Keyer state, level, ramp divider and the status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            level     <= '0;
            div_cnt   <= '0;
            tx_active <= 1'b0;
            tw_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            div_cnt   <= div_nxt;
            tx_active <= tx_active_nxt;
            tw_ready  <= tw_ready_nxt;
        end
    end

    assign div_done = (div_cnt == DIV_LAST);

    // Ramp sequencing; level saturates at 0 and LVL_MAX.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        div_nxt   = div_cnt;

        case (state)
            IDLE: begin
                if (key_db) begin
                    state_nxt = RAMP_UP;
                    div_nxt   = '0;
                end
            end
            RAMP_UP: begin
                if (!key_db) begin
                    state_nxt = RAMP_DOWN;
                    div_nxt   = '0;
                end else if (level == LVL_MAX) begin
                    state_nxt = ON;
                end else if (div_done) begin
                    div_nxt   = '0;
                    level_nxt = level + LVL_ONE;
                    if (level == (LVL_MAX - LVL_ONE)) begin
                        state_nxt = ON;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            ON: begin
                if (!key_db) begin
                    state_nxt = RAMP_DOWN;
                    div_nxt   = '0;
                end
            end
            RAMP_DOWN: begin
                if (key_db) begin
                    state_nxt = RAMP_UP;
                    div_nxt   = '0;
                end else if (level == LVL_ZERO) begin
                    state_nxt = IDLE;
                end else if (div_done) begin
                    div_nxt   = '0;
                    level_nxt = level - LVL_ONE;
                    if (level == LVL_ONE) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = '0;
                div_nxt   = '0;
            end
        endcase

        tx_active_nxt = (state_nxt != IDLE);
        tw_ready_nxt  = (state_nxt == IDLE) || (state_nxt == ON);
    end

endmodule

// File: tb/tb_tx_nco_keyer.sv
// Directed bench for tx_nco_keyer with an rf_out scoreboard driven by a bench-side NCO model.
module tb_tx_nco_keyer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_in;
    logic [31:0] tw_data;
    logic        tw_valid;
    logic        tw_ready;
    logic        rf_out;
    logic        tx_active;
    logic [3:0]  level;

    int          checks = 0;
    int          errors = 0;

    // Bench model of the accumulator; sb_mode: 0 idle, 1 expect rf_out=0, 2 expect carrier.
    logic [31:0] m_acc;
    logic [31:0] m_tw;
    int          sb_mode;
    logic        sb_q[$];

    tx_nco_keyer #(
        .ACC_W        (32),
        .LVL_W        (3),
        .RAMP_DIV     (2),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .tw_data   (tw_data),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .rf_out    (rf_out),
        .tx_active (tx_active),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model, compare the oldest expected rf_out, push the next one.
    task automatic step(input bit load);
        logic exp_rf;
        @(posedge clk);
        if (!rst_n) begin
            m_acc = '0;
            m_tw  = '0;
        end else begin
            m_acc = m_acc + m_tw;
            if (load) m_tw = tw_data;
        end
        #1;
        if (sb_q.size() != 0) begin
            exp_rf = sb_q.pop_front();
            check("rf_sb", 64'(rf_out), 64'(exp_rf));
        end
        if (sb_mode == 1) sb_q.push_back(1'b0);
        else if (sb_mode == 2) sb_q.push_back(m_acc[31]);
    endtask

    initial begin
        int   cnt_d;
        int   cnt_m;
        logic prev_d;
        logic prev_m;
        logic ok_a;
        logic ok_b;

        rst_n    = 1'b0;
        key_in   = 1'b0;
        tw_data  = '0;
        tw_valid = 1'b0;
        m_acc    = '0;
        m_tw     = '0;
        sb_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_rf_out", 64'(rf_out), 64'(0));
        check("rst_tx_active", 64'(tx_active), 64'(0));
        check("rst_tw_ready", 64'(tw_ready), 64'(1));
        check("rst_level", 64'(level), 64'(0));

        // 1: quarter-rate carrier, level 0 keeps rf_out low
        sb_mode  = 1;
        tw_data  = 32'h4000_0000;
        tw_valid = 1'b1;
        check("t1_ready", 64'(tw_ready), 64'(1));
        step(1);
        tw_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(0);
            check("t1_msb", 64'(dut.acc[31]), 64'((k % 4) >= 2));
        end
        check("t1_acc", 64'(dut.acc), 64'(m_acc));

        // 2: 1 MHz carrier, average period 12 cycles
        tw_data  = 32'd357913941;
        tw_valid = 1'b1;
        check("t2_ready_load", 64'(tw_ready), 64'(1));
        step(1);
        tw_valid = 1'b0;
        cnt_d  = 0;
        cnt_m  = 0;
        ok_a   = 1'b1;
        prev_d = dut.acc[31];
        prev_m = m_acc[31];
        for (int i = 0; i < 1200; i++) begin
            step(0);
            if (dut.acc[31] && !prev_d) cnt_d++;
            if (m_acc[31] && !prev_m) cnt_m++;
            prev_d = dut.acc[31];
            prev_m = m_acc[31];
            ok_a   = ok_a & (tw_ready === 1'b1);
        end
        check("t2_rises", 64'(cnt_d), 64'(cnt_m));
        check("t2_period", 64'(cnt_d >= 99 && cnt_d <= 100), 64'(1));
        check("t2_ready_hold", 64'(ok_a), 64'(1));
        check("t2_acc", 64'(dut.acc), 64'(m_acc));

        // 4: 3-cycle key glitch is rejected
        key_in = 1'b1;
        repeat (3) step(0);
        key_in = 1'b0;
        ok_a = 1'b1;
        ok_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(0);
            ok_a = ok_a & (dut.u_debounce.key_db === 1'b0);
            ok_b = ok_b & (tx_active === 1'b0) & (level === 4'd0);
        end
        check("t4_key_db", 64'(ok_a), 64'(1));
        check("t4_idle", 64'(ok_b), 64'(1));

        // 3: held key ramps up to ON, rf_out then follows the carrier
        sb_mode = 0;
        key_in  = 1'b1;
        repeat (5) step(0);
        check("t3_db_early", 64'(dut.u_debounce.key_db), 64'(0));
        step(0);
        check("t3_db_rise", 64'(dut.u_debounce.key_db), 64'(1));
        check("t3_still_idle", 64'(tx_active), 64'(0));
        step(0);
        check("t3_active", 64'(tx_active), 64'(1));
        check("t3_ramp_ready", 64'(tw_ready), 64'(0));
        check("t3_lvl0", 64'(level), 64'(0));
        repeat (15) step(0);
        check("t3_lvl7", 64'(level), 64'(7));
        step(0);
        check("t3_lvl8", 64'(level), 64'(8));
        check("t3_on_ready", 64'(tw_ready), 64'(1));
        sb_mode = 2;
        repeat (24) step(0);
        tw_data  = 32'h4000_0000;
        tw_valid = 1'b1;
        check("t3_on_accept", 64'(tw_ready), 64'(1));
        step(1);
        tw_valid = 1'b0;
        repeat (12) step(0);
        check("t3_active_on", 64'(tx_active), 64'(1));

        // 6: asynchronous reset while ON
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rf_async", 64'(rf_out), 64'(0));
        check("t6_lvl_async", 64'(level), 64'(0));
        check("t6_act_async", 64'(tx_active), 64'(0));
        sb_mode = 0;
        sb_q.delete();
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_acc = '0;
        m_tw  = '0;
        check("t6_ready", 64'(tw_ready), 64'(1));
        check("t6_tw", 64'(dut.tw), 64'(0));
        repeat (3) step(0);
        check("t6_acc_frozen", 64'(dut.acc), 64'(m_acc));
        check("t6_idle", 64'(tx_active), 64'(0));

        // 5: release at level 5, ramp down, deferred tuning handshake
        key_in = 1'b1;
        repeat (7) step(0);
        check("t5_ramp_ready", 64'(tw_ready), 64'(0));
        repeat (4) step(0);
        check("t5_lvl2", 64'(level), 64'(2));
        key_in = 1'b0;
        repeat (6) step(0);
        check("t5_lvl5", 64'(level), 64'(5));
        tw_data  = 32'h1000_0000;
        tw_valid = 1'b1;
        step(0);
        check("t5_down_lvl5", 64'(level), 64'(5));
        check("t5_down_ready", 64'(tw_ready), 64'(0));
        step(0);
        step(0);
        check("t5_lvl4", 64'(level), 64'(4));
        repeat (7) step(0);
        check("t5_lvl1", 64'(level), 64'(1));
        check("t5_lvl1_active", 64'(tx_active), 64'(1));
        check("t5_tw_held", 64'(dut.tw), 64'(0));
        step(0);
        check("t5_lvl0", 64'(level), 64'(0));
        check("t5_idle", 64'(tx_active), 64'(0));
        check("t5_idle_ready", 64'(tw_ready), 64'(1));
        step(1);
        tw_valid = 1'b0;
        check("t5_tw_loaded", 64'(dut.tw), 64'(32'h1000_0000));
        repeat (4) step(0);
        check("t5_acc", 64'(dut.acc), 64'(m_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
